ball_motion: RTL and testbench

- Per-ball motion integrator; it consumes the post-collision velocity interface (collisionOccurred plus the velocity-out buses) produced by the hit controller.
- Owns each ball's fixed-point position and velocity.
- Once per video frame it advances position by velocity, reflects velocity off table cushions and applies rolling friction.
- Drives the top-left position and velocity consumed by the drawing logic and by the collision block, closing the loop.

---
 rtl/billiard_pkg.sv | 30 +++
 rtl/ball_motion_if.sv | 33 +++
 rtl/ball_motion_vel_axis.sv | 47 ++++
 rtl/ball_motion.sv | 111 +++++++++++
 tb/tb_ball_motion.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/billiard_pkg.sv
// Shared types and constants for the billiard ball motion logic.
package billiard_pkg;

  typedef logic signed [10:0] vel_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_APPLY    = 2'd1,
    S_WALL     = 2'd2,
    S_FRICTION = 2'd3
  } motion_state_e;

  localparam int FRAC_BITS_DEF = 4;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int CUSHION_LEFT = 32;
  localparam int CUSHION_RIGHT = SCREEN_W - 32;
  localparam int CUSHION_TOP  = 32;
  localparam int CUSHION_BOTTOM = SCREEN_H - 32;

  function automatic vel_t clamp_vel(input vel_t v, input vel_t lim);
    vel_t r;
    r = v;
    if (v > lim) r = lim;
    else if (v < -lim) r = -lim;
    return r;
  endfunction

endpackage

// File: rtl/ball_motion_if.sv
// Velocity-load inputs and position/velocity outputs of one ball.
interface ball_motion_if;
  import billiard_pkg::*;

  logic startOfFrame;
  logic collisionOccurred;
  vel_t collVelX;
  vel_t collVelY;
  logic cueHit;
  vel_t cueVelX;
  vel_t cueVelY;
  logic wallHitX;
  logic wallHitY;
  logic wallSideX;
  logic wallSideY;
  vel_t ballTopLeftPosX;
  vel_t ballTopLeftPosY;
  vel_t ballVelX;
  vel_t ballVelY;
  logic moving;

  modport master (
    output startOfFrame, collisionOccurred, collVelX, collVelY,
           cueHit, cueVelX, cueVelY, wallHitX, wallHitY, wallSideX, wallSideY,
    input  ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY, moving
  );

  modport slave (
    input  startOfFrame, collisionOccurred, collVelX, collVelY,
           cueHit, cueVelX, cueVelY, wallHitX, wallHitY, wallSideX, wallSideY,
    output ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY, moving
  );
endinterface

// File: rtl/ball_motion_vel_axis.sv
// One velocity component: clamped load, reflection and friction toward zero.
module vel_axis
  import billiard_pkg::*;
#(
  parameter vel_t MAX_VEL       = 11'sd480,
  parameter int   FRICTION_STEP = 1
) (
  input  logic clk,
  input  logic resetN,
  input  logic cue_load,
  input  vel_t cue_vel,
  input  logic coll_load,
  input  vel_t coll_vel,
  input  logic reflect,
  input  logic friction,
  output vel_t vel
);

  localparam vel_t STEP = vel_t'(FRICTION_STEP);

  vel_t vel_reg;
  vel_t vel_next;

  // Loads win over the frame-driven updates; friction stops at zero.
  always_comb begin
    vel_next = vel_reg;
    if (cue_load) begin
      vel_next = clamp_vel(cue_vel, MAX_VEL);
    end else if (coll_load) begin
      vel_next = clamp_vel(coll_vel, MAX_VEL);
    end else if (reflect) begin
      vel_next = -vel_reg;
    end else if (friction) begin
      if (vel_reg > STEP) vel_next = vel_reg - STEP;
      else if (vel_reg < -STEP) vel_next = vel_reg + STEP;
      else vel_next = '0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) vel_reg <= '0;
    else vel_reg <= vel_next;
  end

  assign vel = vel_reg;

endmodule

// File: rtl/ball_motion.sv
// Per-ball motion integrator: once per frame apply velocity, bounce off
// cushions and apply periodic rolling friction.
module ball_motion
  import billiard_pkg::*;
#(
  parameter vel_t INIT_X          = 11'sd100,
  parameter vel_t INIT_Y          = 11'sd100,
  parameter int   FRAC_BITS       = FRAC_BITS_DEF,
  parameter vel_t MAX_VEL         = 11'sd480,
  parameter int   FRICTION_PERIOD = 4,
  parameter int   FRICTION_STEP   = 1
) (
  input  logic clk,
  input  logic resetN,
  ball_motion_if.slave bus
);

  localparam int ACC_W = 11 + FRAC_BITS;

  motion_state_e state_reg, state_next;
  logic [7:0]    fric_cnt_reg;
  logic          fric_due;
  logic          moving_reg;
  vel_t          vel [2];
  vel_t          pos [2];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (bus.startOfFrame) state_next = S_APPLY;
      S_APPLY:    state_next = S_WALL;
      S_WALL:     state_next = S_FRICTION;
      S_FRICTION: state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  assign fric_due = (state_reg == S_FRICTION) &&
                    (fric_cnt_reg == 8'(FRICTION_PERIOD - 1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg    <= S_IDLE;
      fric_cnt_reg <= '0;
      moving_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      moving_reg <= (vel[0] != 11'sd0) || (vel[1] != 11'sd0);
      if (state_reg == S_FRICTION)
        fric_cnt_reg <= fric_due ? 8'd0 : fric_cnt_reg + 8'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      localparam vel_t INIT_P = (gi == 0) ? INIT_X : INIT_Y;

      logic                    wall_hit;
      logic                    wall_side;
      logic                    reflect;
      logic                    latch_reg;
      logic signed [ACC_W-1:0] acc_reg;

      assign wall_hit  = (gi == 0) ? bus.wallHitX  : bus.wallHitY;
      assign wall_side = (gi == 0) ? bus.wallSideX : bus.wallSideY;

      // Only bounce when heading into the cushion and not already bounced.
      assign reflect = (state_reg == S_WALL) && wall_hit && !latch_reg &&
                       (wall_side ? (vel[gi] > 11'sd0) : (vel[gi] < 11'sd0));

      vel_axis #(
        .MAX_VEL       (MAX_VEL),
        .FRICTION_STEP (FRICTION_STEP)
      ) u_vel (
        .clk       (clk),
        .resetN    (resetN),
        .cue_load  (bus.cueHit),
        .cue_vel   ((gi == 0) ? bus.cueVelX : bus.cueVelY),
        .coll_load (bus.collisionOccurred),
        .coll_vel  ((gi == 0) ? bus.collVelX : bus.collVelY),
        .reflect   (reflect),
        .friction  (fric_due),
        .vel       (vel[gi])
      );

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          latch_reg <= 1'b0;
          acc_reg   <= {INIT_P, {FRAC_BITS{1'b0}}};
        end else begin
          if (state_reg == S_WALL) begin
            if (!wall_hit) latch_reg <= 1'b0;
            else if (reflect) latch_reg <= 1'b1;
          end
          if (state_reg == S_APPLY)
            acc_reg <= acc_reg + ACC_W'(vel[gi]);
        end
      end

      assign pos[gi] = acc_reg[ACC_W-1:FRAC_BITS];
    end
  endgenerate

  assign bus.ballTopLeftPosX = pos[0];
  assign bus.ballTopLeftPosY = pos[1];
  assign bus.ballVelX        = vel[0];
  assign bus.ballVelY        = vel[1];
  assign bus.moving          = moving_reg;

endmodule

// File: tb/tb_ball_motion.sv
// Directed and randomized checks of ball_motion against a frame-level model.
module tb_ball_motion;
  import billiard_pkg::*;

  logic clk;
  logic resetN;
  int   n_assert;
  int   n_fail;

  // Frame-level reference: sub-pixel positions, velocities, bounce latches.
  int                mv [2];
  logic signed [14:0] ma [2];
  bit                ml [2];
  int                m_frames;

  ball_motion_if bus ();

  ball_motion dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampv(input int v);
    if (v > 480) return 480;
    if (v < -480) return -480;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0;
      ma[i] = 15'sd1600;
      ml[i] = 1'b0;
    end
    m_frames = 0;
  endtask

  task automatic model_frame(input bit hx, input bit sx, input bit hy, input bit sy);
    bit h [2];
    bit s [2];
    h[0] = hx; h[1] = hy; s[0] = sx; s[1] = sy;
    m_frames++;
    for (int i = 0; i < 2; i++) begin
      ma[i] = ma[i] + 15'(mv[i]);
      if (!h[i]) ml[i] = 1'b0;
      else if (!ml[i] && (s[i] ? (mv[i] > 0) : (mv[i] < 0))) begin
        mv[i] = -mv[i];
        ml[i] = 1'b1;
      end
      if (m_frames % 4 == 0) begin
        if (mv[i] > 0) mv[i] = mv[i] - 1;
        else if (mv[i] < 0) mv[i] = mv[i] + 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".posx"}, bus.ballTopLeftPosX, int'(ma[0] >>> 4));
    chk({tag, ".posy"}, bus.ballTopLeftPosY, int'(ma[1] >>> 4));
    chk({tag, ".velx"}, bus.ballVelX, mv[0]);
    chk({tag, ".vely"}, bus.ballVelY, mv[1]);
    chk({tag, ".moving"}, bus.moving, (mv[0] != 0 || mv[1] != 0) ? 1 : 0);
  endtask

  task automatic clear_inputs();
    bus.startOfFrame = 0; bus.collisionOccurred = 0; bus.cueHit = 0;
    bus.collVelX = '0; bus.collVelY = '0; bus.cueVelX = '0; bus.cueVelY = '0;
    bus.wallHitX = 0; bus.wallHitY = 0; bus.wallSideX = 0; bus.wallSideY = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetN = 0;
    step();
    step();
    resetN = 1;
    step();
    model_reset();
  endtask

  task automatic cue(input vel_t vx, input vel_t vy);
    bus.cueHit = 1; bus.cueVelX = vx; bus.cueVelY = vy;
    step();
    bus.cueHit = 0;
    mv[0] = clampv(int'(vx));
    mv[1] = clampv(int'(vy));
  endtask

  task automatic frame(input bit coll, input vel_t cx, input vel_t cy);
    bus.startOfFrame = 1;
    if (coll) begin
      bus.collisionOccurred = 1; bus.collVelX = cx; bus.collVelY = cy;
      mv[0] = clampv(int'(cx));
      mv[1] = clampv(int'(cy));
    end
    step();
    bus.startOfFrame = 0;
    bus.collisionOccurred = 0;
    repeat (4) step();
    model_frame(bus.wallHitX, bus.wallSideX, bus.wallHitY, bus.wallSideY);
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    resetN = 1;
    clear_inputs();
    model_reset();

    // Idle after reset: ball stays put across ten frames.
    do_reset();
    check_all("reset");
    for (int f = 0; f < 10; f++) frame(0, '0, '0);
    check_all("idle10");
    chk("idle10.posx_const", bus.ballTopLeftPosX, 100);

    // Cue strike, integration, friction on the fourth frame.
    do_reset();
    cue(11'sd32, -11'sd16);
    chk("cue.velx", bus.ballVelX, 32);
    frame(0, '0, '0);
    chk("cue1.posx", bus.ballTopLeftPosX, 102);
    chk("cue1.posy", bus.ballTopLeftPosY, 99);
    for (int f = 0; f < 3; f++) frame(0, '0, '0);
    chk("cue4.velx", bus.ballVelX, 31);
    chk("cue4.vely", bus.ballVelY, -15);
    check_all("cue4");

    // Clamping of out-of-range loads.
    do_reset();
    cue(11'sd600, -11'sd600);
    chk("clamp.velx", bus.ballVelX, 480);
    chk("clamp.vely", bus.ballVelY, -480);
    cue(-11'sd1024, 11'sd1023);
    chk("clamp2.velx", bus.ballVelX, -480);
    chk("clamp2.vely", bus.ballVelY, 480);

    // Left cushion: single bounce while held, latch re-arms after release.
    do_reset();
    cue(-11'sd20, 11'sd0);
    bus.wallHitX = 1; bus.wallSideX = 0;
    frame(0, '0, '0);
    chk("wall1.velx", bus.ballVelX, 20);
    frame(0, '0, '0);
    chk("wall2.velx", bus.ballVelX, 20);
    cue(-11'sd20, 11'sd0);
    frame(0, '0, '0);
    chk("wall_latched.velx", bus.ballVelX, -20);
    bus.wallHitX = 0;
    frame(0, '0, '0);
    check_all("wall_release");
    bus.wallHitX = 1;
    frame(0, '0, '0);
    chk("wall_rearm.velx", bus.ballVelX, 19);
    check_all("wall_rearm");
    bus.wallHitX = 0;

    // Collision load coinciding with startOfFrame is used by that frame.
    do_reset();
    frame(1, 11'sd32, -11'sd24);
    chk("collsof.posx", bus.ballTopLeftPosX, 102);
    chk("collsof.posy", bus.ballTopLeftPosY, 98);
    check_all("collsof");

    // Cue and collision together: cue wins.
    do_reset();
    bus.cueHit = 1; bus.cueVelX = 11'sd10; bus.cueVelY = 11'sd10;
    bus.collisionOccurred = 1; bus.collVelX = 11'sd200; bus.collVelY = 11'sd200;
    step();
    clear_inputs();
    chk("cuewins.velx", bus.ballVelX, 10);
    chk("cuewins.vely", bus.ballVelY, 10);

    // Friction takes velX=1 to 0; moving drops one cycle later.
    do_reset();
    cue(11'sd1, 11'sd0);
    for (int f = 0; f < 3; f++) frame(0, '0, '0);
    bus.startOfFrame = 1;
    step();
    bus.startOfFrame = 0;
    repeat (3) step();
    chk("fric0.velx", bus.ballVelX, 0);
    chk("fric0.moving_hold", bus.moving, 1);
    step();
    chk("fric0.moving_drop", bus.moving, 0);
    model_frame(0, 0, 0, 0);
    check_all("fric0");

    // Reset in the middle of frame processing.
    do_reset();
    cue(11'sd50, 11'sd50);
    bus.startOfFrame = 1;
    step();
    bus.startOfFrame = 0;
    step();
    resetN = 0;
    #1;
    chk("midrst.posx", bus.ballTopLeftPosX, 100);
    chk("midrst.posy", bus.ballTopLeftPosY, 100);
    chk("midrst.velx", bus.ballVelX, 0);
    chk("midrst.moving", bus.moving, 0);
    step();
    resetN = 1;
    step();
    model_reset();
    cue(11'sd16, 11'sd48);
    frame(0, '0, '0);
    check_all("midrst_resume");

    // Randomized frames with cue strikes, collisions and cushion contacts.
    do_reset();
    for (int f = 0; f < 80; f++) begin
      if ($urandom_range(0, 2) == 0)
        cue(vel_t'($urandom_range(0, 2047)), vel_t'($urandom_range(0, 2047)));
      bus.wallHitX  = ($urandom_range(0, 3) == 0);
      bus.wallSideX = 1'($urandom_range(0, 1));
      bus.wallHitY  = ($urandom_range(0, 3) == 0);
      bus.wallSideY = 1'($urandom_range(0, 1));
      frame($urandom_range(0, 3) == 0, vel_t'($urandom_range(0, 2047)),
            vel_t'($urandom_range(0, 2047)));
      check_all($sformatf("rand%0d", f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
